img_buffer_ctrl: RTL and testbench

IMG_BUFFER_CTRL -- requirements
Module: img_buffer_ctrl

---
 rtl/img_buf_pkg.sv | 18 +
 rtl/img_buffer_ctrl_if.sv | 25 ++
 rtl/img_byte_store.sv | 39 +++
 rtl/img_buffer_ctrl.sv | 158 +++++++++++++++
 tb/tb_img_buffer_ctrl.sv | 247 ++++++++++++++++++++++++
 5 files changed

// File: rtl/img_buf_pkg.sv
// Shared types and defaults for the image buffer controller.
// Optional result watchdog is enabled with the IMG_BUF_TIMEOUT_EN macro.
package img_buf_pkg;

  localparam int unsigned IMG_BITS_DEFAULT  = 904;
  localparam int unsigned IMG_BYTES_DEFAULT = 113;
  localparam int unsigned TIMEOUT_DEFAULT   = 4096;
  localparam int unsigned FILL_CNT_W        = 7;
  localparam logic [3:0]  TIMEOUT_RESULT    = 4'hF;

  typedef enum logic [1:0] {
    FILL     = 2'd0,
    WAIT_RES = 2'd1,
    CLEAR    = 2'd2,
    REPORT   = 2'd3
  } state_t;

endpackage

// File: rtl/img_buffer_ctrl_if.sv
// Host-side link: byte stream in (valid/ready), result out (valid/ack), abort and status.
// master = host, slave = image buffer controller.
interface img_buffer_ctrl_if;

  logic [7:0]                        rx_data;
  logic                              rx_valid;
  logic                              rx_ready;
  logic                              clear_req;
  logic [3:0]                        res_data;
  logic                              res_valid;
  logic                              res_ack;
  logic                              res_timeout;
  logic [img_buf_pkg::FILL_CNT_W-1:0] fill_count;

  modport master (
    output rx_data, rx_valid, clear_req, res_ack,
    input  rx_ready, res_data, res_valid, res_timeout, fill_count
  );

  modport slave (
    input  rx_data, rx_valid, clear_req, res_ack,
    output rx_ready, res_data, res_valid, res_timeout, fill_count
  );

endinterface

// File: rtl/img_byte_store.sv
// Image register: byte k lands at img[IMG_BITS-1-8k -: 8], one write per cycle, no backpressure.
// Contents persist across images; only reset clears them.
module img_byte_store
  import img_buf_pkg::*;
#(
  parameter int unsigned IMG_BITS  = IMG_BITS_DEFAULT,
  parameter int unsigned IMG_BYTES = IMG_BYTES_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [FILL_CNT_W-1:0] wr_idx,
  input  logic [7:0]            wr_dat,
  output logic [IMG_BITS-1:0]   img
);

  logic [IMG_BITS-1:0] img_q;
  logic [IMG_BITS-1:0] img_d;

  always_comb begin
    img_d = img_q;
    for (int k = 0; k < int'(IMG_BYTES); k++) begin
      if (wr_en && (wr_idx == FILL_CNT_W'(k))) begin
        img_d[IMG_BITS-1-8*k -: 8] = wr_dat;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      img_q <= '0;
    end else begin
      img_q <= img_d;
    end
  end

  assign img = img_q;

endmodule

// File: rtl/img_buffer_ctrl.sv
// Collects IMG_BYTES host bytes, runs one BNN inference, reports the digit back to the host.
// rx_ready only in FILL; result held until res_ack; clear_req aborts. Watchdog: IMG_BUF_TIMEOUT_EN.
module img_buffer_ctrl
  import img_buf_pkg::*;
#(
  parameter int unsigned IMG_BITS       = IMG_BITS_DEFAULT,
  parameter int unsigned IMG_BYTES      = IMG_BYTES_DEFAULT,
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst_n,
  img_buffer_ctrl_if.slave     host,
  output logic [IMG_BITS-1:0]  img_out,
  output logic                 img_buffer_full,
  output logic                 bnn_enable,
  output logic                 bnn_clear,
  input  logic [3:0]           result_in,
  input  logic                 result_ready
);

  state_t                state_q, state_d;
  logic [FILL_CNT_W-1:0] fill_count_q, fill_count_d;
  logic                  rx_ready_q, rx_ready_d;
  logic [3:0]            res_data_q, res_data_d;
  logic                  res_timeout_q, res_timeout_d;
  logic                  skip_report_q, skip_report_d;
  logic                  wr_en;
  logic                  accept;
  logic                  to_fire;

`ifdef IMG_BUF_TIMEOUT_EN
  localparam int unsigned TMR_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMR_W-1:0] tmr_q, tmr_d;

  // Counter restarts from zero on every entry to WAIT_RES.
  always_comb begin
    tmr_d   = '0;
    to_fire = 1'b0;
    if (state_q == WAIT_RES) begin
      tmr_d   = tmr_q + 1'b1;
      to_fire = (tmr_q == TMR_W'(TIMEOUT_CYCLES - 1));
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tmr_q <= '0;
    end else begin
      tmr_q <= tmr_d;
    end
  end
`else
  assign to_fire = 1'b0;
`endif

  assign accept = (state_q == FILL) && rx_ready_q && host.rx_valid && !host.clear_req;

  always_comb begin
    state_d       = state_q;
    fill_count_d  = fill_count_q;
    res_data_d    = res_data_q;
    res_timeout_d = res_timeout_q;
    skip_report_d = skip_report_q;
    wr_en         = 1'b0;

    case (state_q)
      FILL: begin
        if (host.clear_req) begin
          fill_count_d = '0;
        end else if (accept) begin
          wr_en        = 1'b1;
          fill_count_d = fill_count_q + 1'b1;
          if (fill_count_q == FILL_CNT_W'(IMG_BYTES - 1)) begin
            state_d = WAIT_RES;
          end
        end
      end
      WAIT_RES: begin
        if (host.clear_req) begin
          state_d       = CLEAR;
          skip_report_d = 1'b1;
        end else if (result_ready) begin
          state_d       = CLEAR;
          res_data_d    = result_in;
          skip_report_d = 1'b0;
        end else if (to_fire) begin
          state_d       = CLEAR;
          res_data_d    = TIMEOUT_RESULT;
          res_timeout_d = 1'b1;
          skip_report_d = 1'b0;
        end
      end
      CLEAR: begin
        // An abort seen here or in WAIT_RES drops the result and skips REPORT.
        if (skip_report_q || host.clear_req) begin
          state_d       = FILL;
          fill_count_d  = '0;
          res_timeout_d = 1'b0;
          skip_report_d = 1'b0;
        end else begin
          state_d = REPORT;
        end
      end
      REPORT: begin
        if (host.clear_req || host.res_ack) begin
          state_d       = FILL;
          fill_count_d  = '0;
          res_timeout_d = 1'b0;
        end
      end
      default: begin
        state_d = FILL;
      end
    endcase

    rx_ready_d = (state_d == FILL);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= FILL;
      fill_count_q  <= '0;
      rx_ready_q    <= 1'b0;
      res_data_q    <= '0;
      res_timeout_q <= 1'b0;
      skip_report_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      fill_count_q  <= fill_count_d;
      rx_ready_q    <= rx_ready_d;
      res_data_q    <= res_data_d;
      res_timeout_q <= res_timeout_d;
      skip_report_q <= skip_report_d;
    end
  end

  img_byte_store #(
    .IMG_BITS  (IMG_BITS),
    .IMG_BYTES (IMG_BYTES)
  ) u_store (
    .clk    (clk),
    .rst_n  (rst_n),
    .wr_en  (wr_en),
    .wr_idx (fill_count_q),
    .wr_dat (host.rx_data),
    .img    (img_out)
  );

  assign host.rx_ready    = rx_ready_q;
  assign host.fill_count  = fill_count_q;
  assign host.res_data    = res_data_q;
  assign host.res_valid   = (state_q == REPORT);
  assign host.res_timeout = res_timeout_q;
  assign img_buffer_full  = (state_q != FILL);
  assign bnn_enable       = (state_q == WAIT_RES);
  assign bnn_clear        = (state_q == CLEAR);

endmodule

// File: tb/tb_img_buffer_ctrl.sv
// Directed bench for img_buffer_ctrl; the watchdog scenario replaces the indefinite-wait one
// when IMG_BUF_TIMEOUT_EN is defined.
module tb_img_buffer_ctrl;

  localparam int NB = 113;
  localparam int IB = 904;
`ifdef IMG_BUF_TIMEOUT_EN
  localparam int TO = 16;
`else
  localparam int TO = 4096;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [IB-1:0] img_out;
  logic          img_buffer_full, bnn_enable, bnn_clear;
  logic [3:0]    result_in = 4'h0;
  logic          result_ready = 1'b0;
  int            checks = 0;
  int            errors = 0;

  img_buffer_ctrl_if hif();

  img_buffer_ctrl #(
    .IMG_BITS       (IB),
    .IMG_BYTES      (NB),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .host            (hif),
    .img_out         (img_out),
    .img_buffer_full (img_buffer_full),
    .bnn_enable      (bnn_enable),
    .bnn_clear       (bnn_clear),
    .result_in       (result_in),
    .result_ready    (result_ready)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic fill_image(input logic [7:0] base);
    for (int k = 0; k < NB; k++) begin
      hif.rx_data  = base + 8'(k);
      hif.rx_valid = 1'b1;
      step();
    end
    hif.rx_valid = 1'b0;
  endtask

  task automatic test_reset();
    hif.rx_data = 8'h00; hif.rx_valid = 1'b0; hif.clear_req = 1'b0; hif.res_ack = 1'b0;
    rst_n = 1'b0;
    step();
    step();
    checks++; if (hif.rx_ready !== 1'b0) begin errors++; $display("FAIL reset_rx_ready got %b exp 0", hif.rx_ready); end
    checks++; if (img_out !== '0) begin errors++; $display("FAIL reset_img_out got nonzero exp 0"); end
    checks++; if ({img_buffer_full, bnn_enable, bnn_clear, hif.res_valid, hif.res_timeout} !== 5'b0) begin
      errors++; $display("FAIL reset_flags got %b exp 00000", {img_buffer_full, bnn_enable, bnn_clear, hif.res_valid, hif.res_timeout}); end
    checks++; if ({hif.res_data, hif.fill_count} !== 11'h0) begin
      errors++; $display("FAIL reset_counts got res_data %h fill %0d exp 0 0", hif.res_data, hif.fill_count); end
    rst_n = 1'b1;
    step();
    checks++; if (hif.rx_ready !== 1'b1) begin errors++; $display("FAIL reset_release_rx_ready got %b exp 1", hif.rx_ready); end
  endtask

  task automatic test_fill();
    hif.res_ack = 1'b1;
    step();
    hif.res_ack = 1'b0;
    checks++; if (hif.res_valid !== 1'b0) begin errors++; $display("FAIL stray_ack_res_valid got %b exp 0", hif.res_valid); end
    result_in = 4'h9;
    for (int k = 0; k < NB; k++) begin
      hif.rx_data  = 8'(k);
      hif.rx_valid = 1'b1;
      result_ready = (k < 3);
      step();
      if (k == 111) begin
        checks++; if (hif.fill_count !== 7'd112) begin errors++; $display("FAIL fill_cnt_112 got %0d exp 112", hif.fill_count); end
        checks++; if (img_buffer_full !== 1'b0) begin errors++; $display("FAIL full_early got %b exp 0", img_buffer_full); end
      end
    end
    hif.rx_valid = 1'b0;
    result_ready = 1'b0;
    checks++; if ({img_buffer_full, bnn_enable, hif.rx_ready, bnn_clear} !== 4'b1100) begin
      errors++; $display("FAIL fill_done_flags got %b exp 1100", {img_buffer_full, bnn_enable, hif.rx_ready, bnn_clear}); end
    checks++; if (hif.fill_count !== 7'd113) begin errors++; $display("FAIL fill_cnt_113 got %0d exp 113", hif.fill_count); end
    checks++; if (img_out[903:896] !== 8'h00) begin errors++; $display("FAIL img_byte0 got %h exp 00", img_out[903:896]); end
    checks++; if (img_out[895:888] !== 8'h01) begin errors++; $display("FAIL img_byte1 got %h exp 01", img_out[895:888]); end
    checks++; if (img_out[7:0] !== 8'h70) begin errors++; $display("FAIL img_byte112 got %h exp 70", img_out[7:0]); end
  endtask

  task automatic test_result();
    hif.rx_data = 8'hAA; hif.rx_valid = 1'b1;
    step();
    hif.rx_valid = 1'b0;
    checks++; if (hif.fill_count !== 7'd113 || bnn_enable !== 1'b1) begin
      errors++; $display("FAIL wait_ignores_rx got fill %0d en %b exp 113 1", hif.fill_count, bnn_enable); end
    result_in = 4'h7; result_ready = 1'b1;
    step();
    checks++; if ({bnn_clear, bnn_enable, hif.res_valid} !== 3'b100) begin
      errors++; $display("FAIL clear_pulse got %b exp 100", {bnn_clear, bnn_enable, hif.res_valid}); end
    result_ready = 1'b0;
    step();
    checks++; if ({bnn_clear, hif.res_valid, hif.res_data} !== {2'b01, 4'h7}) begin
      errors++; $display("FAIL report_entry got clr %b vld %b data %h exp 0 1 7", bnn_clear, hif.res_valid, hif.res_data); end
    repeat (3) step();
    checks++; if ({hif.res_valid, hif.res_data, img_buffer_full} !== {1'b1, 4'h7, 1'b1}) begin
      errors++; $display("FAIL report_hold got vld %b data %h full %b exp 1 7 1", hif.res_valid, hif.res_data, img_buffer_full); end
    checks++; if (img_out[7:0] !== 8'h70) begin errors++; $display("FAIL img_hold got %h exp 70", img_out[7:0]); end
    hif.res_ack = 1'b1;
    step();
    hif.res_ack = 1'b0;
    checks++; if ({hif.res_valid, img_buffer_full, hif.rx_ready} !== 3'b001 || hif.fill_count !== 7'd0) begin
      errors++; $display("FAIL after_ack got vld %b full %b rdy %b fill %0d exp 0 0 1 0",
                         hif.res_valid, img_buffer_full, hif.rx_ready, hif.fill_count); end
  endtask

  task automatic test_clear_fill();
    for (int k = 0; k < 50; k++) begin
      hif.rx_data = 8'h80 + 8'(k); hif.rx_valid = 1'b1;
      step();
    end
    hif.rx_data = 8'hEE; hif.clear_req = 1'b1;
    step();
    hif.rx_valid = 1'b0; hif.clear_req = 1'b0;
    checks++; if (hif.fill_count !== 7'd0 || bnn_clear !== 1'b0) begin
      errors++; $display("FAIL clear_fill got fill %0d clr %b exp 0 0", hif.fill_count, bnn_clear); end
    checks++; if (img_out[503:496] !== 8'h32) begin errors++; $display("FAIL discarded_byte got %h exp 32", img_out[503:496]); end
    checks++; if (img_out[511:504] !== 8'hB1) begin errors++; $display("FAIL byte49 got %h exp b1", img_out[511:504]); end
    hif.rx_data = 8'h11; hif.rx_valid = 1'b1;
    step();
    hif.rx_valid = 1'b0;
    checks++; if (img_out[903:896] !== 8'h11 || hif.fill_count !== 7'd1 || bnn_clear !== 1'b0) begin
      errors++; $display("FAIL restart_byte0 got %h fill %0d clr %b exp 11 1 0", img_out[903:896], hif.fill_count, bnn_clear); end
    hif.clear_req = 1'b1;
    step();
    hif.clear_req = 1'b0;
  endtask

  task automatic test_clear_wait();
    logic seen_valid;
    seen_valid = 1'b0;
    fill_image(8'h40);
    result_in = 4'h3; result_ready = 1'b1; hif.clear_req = 1'b1;
    step();
    result_ready = 1'b0; hif.clear_req = 1'b0;
    checks++; if (bnn_clear !== 1'b1) begin errors++; $display("FAIL wait_clear_pulse got %b exp 1", bnn_clear); end
    for (int i = 0; i < 4; i++) begin
      step();
      if (hif.res_valid !== 1'b0 || bnn_clear !== 1'b0) seen_valid = 1'b1;
    end
    checks++; if (seen_valid !== 1'b0) begin errors++; $display("FAIL wait_clear_report got res_valid/clear seen exp none"); end
    checks++; if ({img_buffer_full, hif.rx_ready} !== 2'b01 || hif.fill_count !== 7'd0) begin
      errors++; $display("FAIL wait_clear_fill got full %b rdy %b fill %0d exp 0 1 0", img_buffer_full, hif.rx_ready, hif.fill_count); end
  endtask

`ifdef IMG_BUF_TIMEOUT_EN
  task automatic test_wait_res();
    fill_image(8'h10);
    repeat (15) step();
    checks++; if ({bnn_enable, bnn_clear} !== 2'b10) begin
      errors++; $display("FAIL timeout_early got en %b clr %b exp 1 0", bnn_enable, bnn_clear); end
    step();
    checks++; if ({bnn_clear, hif.res_timeout, hif.res_data} !== {2'b11, 4'hF}) begin
      errors++; $display("FAIL timeout_fire got clr %b to %b data %h exp 1 1 f", bnn_clear, hif.res_timeout, hif.res_data); end
    step();
    checks++; if ({hif.res_valid, hif.res_timeout} !== 2'b11) begin
      errors++; $display("FAIL timeout_report got vld %b to %b exp 1 1", hif.res_valid, hif.res_timeout); end
    hif.res_ack = 1'b1;
    step();
    hif.res_ack = 1'b0;
    checks++; if ({hif.res_valid, hif.res_timeout} !== 2'b00) begin
      errors++; $display("FAIL timeout_ack got vld %b to %b exp 0 0", hif.res_valid, hif.res_timeout); end
  endtask
`else
  task automatic test_wait_res();
    fill_image(8'h10);
    repeat (40) step();
    checks++; if ({bnn_enable, bnn_clear, hif.res_timeout} !== 3'b100) begin
      errors++; $display("FAIL wait_indef got en %b clr %b to %b exp 1 0 0", bnn_enable, bnn_clear, hif.res_timeout); end
    hif.clear_req = 1'b1;
    step();
    hif.clear_req = 1'b0;
    checks++; if (bnn_clear !== 1'b1) begin errors++; $display("FAIL wait_abort_clear got %b exp 1", bnn_clear); end
    step();
    checks++; if ({hif.res_valid, img_buffer_full} !== 2'b00) begin
      errors++; $display("FAIL wait_abort_fill got vld %b full %b exp 0 0", hif.res_valid, img_buffer_full); end
  endtask
`endif

  task automatic test_clear_report();
    fill_image(8'h20);
    result_in = 4'hC; result_ready = 1'b1;
    step();
    result_ready = 1'b0;
    step();
    checks++; if ({hif.res_valid, hif.res_data} !== {1'b1, 4'hC}) begin
      errors++; $display("FAIL report_c got vld %b data %h exp 1 c", hif.res_valid, hif.res_data); end
    hif.clear_req = 1'b1;
    step();
    hif.clear_req = 1'b0;
    checks++; if ({hif.res_valid, img_buffer_full, bnn_clear} !== 3'b000 || hif.fill_count !== 7'd0) begin
      errors++; $display("FAIL report_abort got vld %b full %b clr %b fill %0d exp 0 0 0 0",
                         hif.res_valid, img_buffer_full, bnn_clear, hif.fill_count); end
  endtask

  task automatic test_reset_report();
    fill_image(8'h55);
    result_in = 4'h5; result_ready = 1'b1;
    step();
    result_ready = 1'b0;
    step();
    checks++; if (hif.res_valid !== 1'b1) begin errors++; $display("FAIL pre_reset_report got %b exp 1", hif.res_valid); end
    rst_n = 1'b0;
    step();
    checks++; if ({hif.res_valid, img_buffer_full, bnn_enable, bnn_clear, hif.rx_ready, hif.res_timeout} !== 6'b0) begin
      errors++; $display("FAIL reset_report_flags got %b exp 000000",
                         {hif.res_valid, img_buffer_full, bnn_enable, bnn_clear, hif.rx_ready, hif.res_timeout}); end
    checks++; if (img_out !== '0 || hif.res_data !== 4'h0 || hif.fill_count !== 7'd0) begin
      errors++; $display("FAIL reset_report_data got res_data %h fill %0d img_lo %h exp 0 0 0",
                         hif.res_data, hif.fill_count, img_out[7:0]); end
    rst_n = 1'b1;
    step();
    checks++; if ({hif.rx_ready, hif.res_valid} !== 2'b10) begin
      errors++; $display("FAIL reset_report_release got rdy %b vld %b exp 1 0", hif.rx_ready, hif.res_valid); end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_result();
    test_clear_fill();
    test_clear_wait();
    test_wait_res();
    test_clear_report();
    test_reset_report();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
